// File: rtl/axi_req_master.sv
// ============================================================================
// Module   : axi_req_master
// Brief    : Single-outstanding request/response to AXI4 master bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_req_master #(
    parameter int C_AXI_ADDR_WIDTH = 12,
    parameter int C_AXI_DATA_WIDTH = 128,
    parameter int STRB_WIDTH       = C_AXI_DATA_WIDTH / 8,
    parameter int ID_WIDTH         = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    // request side
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [C_AXI_ADDR_WIDTH-1:0] req_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0]       req_wstrb,
    input  logic [ID_WIDTH-1:0]         req_id,
    // response side
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [C_AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                        rsp_we,
    output logic                        rsp_err,
    output logic [ID_WIDTH-1:0]         rsp_id,
    // AXI4 write address
    output logic [ID_WIDTH-1:0]         m_axi_awid,
    output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    // AXI4 write data
    output logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0]       m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    // AXI4 write response
    input  logic [ID_WIDTH-1:0]         m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    // AXI4 read address
    output logic [ID_WIDTH-1:0]         m_axi_arid,
    output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arcache,
    output logic [2:0]                  m_axi_arprot,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    // AXI4 read data
    input  logic [ID_WIDTH-1:0]         m_axi_rid,
    input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WRITE = 3'd1;
    localparam logic [2:0] c_WRESP = 3'd2;
    localparam logic [2:0] c_RADDR = 3'd3;
    localparam logic [2:0] c_RDATA = 3'd4;
    localparam logic [2:0] c_RSP   = 3'd5;

    localparam int c_SIZE = $clog2(STRB_WIDTH);
    localparam logic [C_AXI_ADDR_WIDTH-1:0] c_ADDR_MASK = {C_AXI_ADDR_WIDTH{1'b1}} << c_SIZE;

    logic [2:0]                  r_state;
    logic                        r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
    logic                        r_aw_done, r_w_done;
    logic                        r_rsp_valid, r_err;
    logic                        r_we;
    logic [C_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_AXI_DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [STRB_WIDTH-1:0]       r_wstrb;
    logic [ID_WIDTH-1:0]         r_id;

    logic w_req_hs, w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;
    logic w_unused;

    // IDs returned by the slave are not needed with a single outstanding transfer
    assign w_unused = ^{m_axi_bid, m_axi_rid};

    assign req_ready = (r_state == c_IDLE) && !rst;
    assign w_req_hs  = req_valid && req_ready;
    assign w_aw_hs   = r_awvalid && m_axi_awready;
    assign w_w_hs    = r_wvalid && m_axi_wready;
    assign w_aw_fin  = r_aw_done || w_aw_hs;
    assign w_w_fin   = r_w_done || w_w_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req_hs) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (req_we) begin
                            r_state   <= c_WRITE;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= c_RADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                c_WRITE: begin
                    // AW and W retire independently, in either order
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_state  <= c_WRESP;
                        r_bready <= 1'b1;
                    end
                end
                c_WRESP: begin
                    if (m_axi_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_err       <= (m_axi_bresp != 2'b00);
                        r_state     <= c_RSP;
                    end
                end
                c_RADDR: begin
                    if (m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= c_RDATA;
                    end
                end
                c_RDATA: begin
                    if (m_axi_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_err       <= (m_axi_rresp != 2'b00) || !m_axi_rlast;
                        r_state     <= c_RSP;
                    end
                end
                c_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_hs) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            r_id    <= req_id;
        end
        if (r_bready && m_axi_bvalid) begin
            r_rdata <= '0;
        end
        if (r_rready && m_axi_rvalid) begin
            r_rdata <= m_axi_rdata;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_we    = r_we;
    assign rsp_err   = r_err;
    assign rsp_id    = r_id;

    assign m_axi_awid    = r_id;
    assign m_axi_awaddr  = r_addr & c_ADDR_MASK;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'(c_SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0000;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;

    assign m_axi_wdata  = r_wdata;
    assign m_axi_wstrb  = r_wstrb;
    assign m_axi_wlast  = r_wvalid;
    assign m_axi_wvalid = r_wvalid;

    assign m_axi_bready = r_bready;

    assign m_axi_arid    = r_id;
    assign m_axi_araddr  = r_addr & c_ADDR_MASK;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'(c_SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0000;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;

    assign m_axi_rready = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_axi_req_master.sv
// ============================================================================
// Module   : tb_axi_req_master
// Brief    : Scoreboard bench for axi_req_master with a behavioural AXI4 RAM slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_req_master;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [11:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [15:0]  req_wstrb = '0;
    logic [0:0]   req_id = '0;
    logic         rsp_valid, rsp_ready = 1'b1, rsp_we, rsp_err;
    logic [127:0] rsp_rdata;
    logic [0:0]   rsp_id;

    logic [0:0]   awid, arid, bid = '0, rid = '0;
    logic [11:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize, awprot, arprot;
    logic [1:0]   awburst, arburst, bresp = '0, rresp = '0;
    logic         awlock, arlock;
    logic [3:0]   awcache, arcache;
    logic         awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast;
    logic [127:0] wdata, rdata = '0;
    logic [15:0]  wstrb;
    logic         bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic         rlast = 1'b0, rvalid = 1'b0, rready;

    axi_req_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_id(req_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_we(rsp_we), .rsp_err(rsp_err), .rsp_id(rsp_id),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
        .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [127:0] rdata;
        logic         we;
        logic         err;
        logic [0:0]   id;
    } exp_t;
    exp_t sb[$];

    logic [127:0] ref_mem [256];
    logic [127:0] mem [256];

    // slave configuration and observation
    int         aw_lat = 0, w_lat = 0, aw_wait = 0, w_wait = 0;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic       cfg_rlast = 1'b1, b_block = 1'b0;
    int         n_bhs = 0, viol = 0;
    logic       aw_only = 1'b0, w_only = 1'b0;
    logic [11:0] last_awaddr = '0, last_araddr = '0;
    logic [2:0]  last_awsize = '0;
    logic [7:0]  last_awlen = '0;
    logic [1:0]  last_awburst = '0;
    logic [0:0]  last_awid = '0, last_arid = '0;

    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, s_rst;
        logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rst;
        logic [11:0] p_awaddr, p_araddr, s_awaddr;
        logic [127:0] p_wdata, s_wdata;
        logic [15:0] p_wstrb, s_wstrb;
        logic s_aw_got, s_w_got, b_pending;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rst = 1;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
        s_aw_got = 0; s_w_got = 0; b_pending = 0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (!p_rst && p_awv && !p_awr && (!awvalid || awaddr != p_awaddr)) viol++;
            if (!p_rst && p_wv && !p_wr && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) viol++;
            if (!p_rst && p_arv && !p_arr && (!arvalid || araddr != p_araddr)) viol++;
            if (wvalid && !wlast) viol++;
            if (bready && (awvalid || wvalid || arvalid || rready || rsp_valid)) viol++;
            if (rready && (awvalid || wvalid || arvalid || bready || rsp_valid)) viol++;
            if (awvalid && !wvalid) aw_only = 1'b1;
            if (wvalid && !awvalid) w_only = 1'b1;
            p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
            p_arv = arvalid; p_arr = arready; p_rst = s_rst;
            p_awaddr = awaddr; p_araddr = araddr; p_wdata = wdata; p_wstrb = wstrb;
            if (aw_hs) begin
                s_awaddr = awaddr; s_aw_got = 1; last_awaddr = awaddr; last_awsize = awsize;
                last_awlen = awlen; last_awburst = awburst; last_awid = awid; bid = awid;
            end
            if (w_hs) begin s_wdata = wdata; s_wstrb = wstrb; s_w_got = 1; end
            if (ar_hs) begin last_araddr = araddr; last_arid = arid; end
            if (b_hs) n_bhs++;
            @(posedge clk); #1;
            if (s_rst) begin
                bvalid = 0; rvalid = 0; awready = 0; wready = 0; arready = 0;
                s_aw_got = 0; s_w_got = 0; b_pending = 0; aw_wait = 0; w_wait = 0;
            end else begin
                if (b_hs) bvalid = 0;
                if (r_hs) rvalid = 0;
                if (s_aw_got && s_w_got) begin
                    for (int b = 0; b < 16; b++)
                        if (s_wstrb[b]) mem[s_awaddr[11:4]][8*b +: 8] = s_wdata[8*b +: 8];
                    s_aw_got = 0; s_w_got = 0; b_pending = 1;
                end
                if (b_pending && !b_block && !bvalid) begin
                    bvalid = 1; bresp = cfg_bresp; b_pending = 0;
                end
                if (ar_hs) begin
                    rvalid = 1; rdata = mem[last_araddr[11:4]]; rresp = cfg_rresp;
                    rlast = cfg_rlast; rid = last_arid;
                end
                awready = awvalid && (aw_wait >= aw_lat);
                aw_wait = awvalid ? aw_wait + 1 : 0;
                wready = wvalid && (w_wait >= w_lat);
                w_wait = wvalid ? w_wait + 1 : 0;
                arready = arvalid;
            end
        end
    end

    task automatic do_req(input logic we, input logic [11:0] addr, input logic [127:0] d,
                          input logic [15:0] strb, input logic [0:0] id, input logic err);
        exp_t e;
        logic acc;
        req_we = we; req_addr = addr; req_wdata = d; req_wstrb = strb; req_id = id;
        req_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!acc) check_val("req_accept_timeout", 0, 1);
        if (we) begin
            for (int b = 0; b < 16; b++)
                if (strb[b]) ref_mem[addr[11:4]][8*b +: 8] = d[8*b +: 8];
            e.rdata = '0;
        end else begin
            e.rdata = ref_mem[addr[11:4]];
        end
        e.we = we; e.err = err; e.id = id;
        sb.push_back(e);
    endtask

    task automatic cmp_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_unexpected_rsp"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_rdata"}, rsp_rdata, e.rdata);
            check_val({tag, "_we"}, rsp_we, e.we);
            check_val({tag, "_err"}, rsp_err, e.err);
            check_val({tag, "_id"}, rsp_id, e.id);
        end
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        logic got;
        got = 1'b0;
        lat = 1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            else begin @(posedge clk); #1; lat++; end
        end
        if (got) begin
            cmp_rsp(tag);
            @(posedge clk); #1;
        end else begin
            check_val({tag, "_rsp_timeout"}, 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [11:0] addr,
                       input logic [127:0] d, input logic [15:0] strb, input logic [0:0] id,
                       input logic err, output int lat);
        do_req(we, addr, d, strb, id, err);
        wait_rsp(tag, lat);
    endtask

    initial begin
        int lat;
        logic got;
        logic [127:0] snap;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check_val("rst_rsp_err", rsp_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_req_ready", req_ready, 1);
        @(posedge clk); #1;

        // full-width write and read-back, minimum latency
        txn("wr_full", 1, 12'h040, 128'h0123456789abcdef_fedcba9876543210, 16'hffff, 1, 0, lat);
        check_val("wr_latency", lat, 3);
        check_val("wr_awid", last_awid, 1);
        txn("rd_full", 0, 12'h040, '0, '0, 0, 0, lat);
        check_val("rd_latency", lat, 3);
        check_val("rd_araddr", last_araddr, 12'h040);

        // single-byte write at an unaligned address
        txn("wr_byte", 1, 12'h047, 128'h5a5a5a5a_5a5a5a5a_5a5a5a5a_5a5a5a5a, 16'h0001, 0, 0, lat);
        check_val("awaddr_aligned", last_awaddr, 12'h040);
        check_val("awsize", last_awsize, 3'd4);
        check_val("awlen", last_awlen, 8'd0);
        check_val("awburst", last_awburst, 2'b01);
        txn("rd_byte", 0, 12'h047, '0, '0, 1, 0, lat);

        // AW and W accepted in different orders
        aw_lat = 3; w_lat = 0; aw_only = 0; w_only = 0; n_bhs = 0;
        txn("wr_aw_late", 1, 12'h080, 128'h1111, 16'h00ff, 0, 0, lat);
        check_val("aw_late_aw_only", aw_only, 1);
        check_val("aw_late_w_only", w_only, 0);
        check_val("aw_late_bhs", n_bhs, 1);
        aw_lat = 0; w_lat = 3; aw_only = 0; w_only = 0; n_bhs = 0;
        txn("wr_w_late", 1, 12'h090, 128'h2222, 16'hff00, 1, 0, lat);
        check_val("w_late_w_only", w_only, 1);
        check_val("w_late_aw_only", aw_only, 0);
        check_val("w_late_bhs", n_bhs, 1);
        w_lat = 0;
        txn("rd_080", 0, 12'h080, '0, '0, 0, 0, lat);

        // error responses
        cfg_bresp = 2'b10;
        txn("wr_slverr", 1, 12'h0a0, 128'h33, 16'h0001, 1, 1, lat);
        cfg_bresp = 2'b00; cfg_rresp = 2'b11;
        txn("rd_decerr", 0, 12'h040, '0, '0, 0, 1, lat);
        cfg_rresp = 2'b00; cfg_rlast = 1'b0;
        txn("rd_nolast", 0, 12'h090, '0, '0, 1, 1, lat);
        cfg_rlast = 1'b1;

        // response back-pressure with a queued request
        do_req(0, 12'h040, '0, '0, 1, 0);
        rsp_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_val("stall_rsp_seen", got, 1);
        snap = rsp_rdata;
        req_we = 1'b0; req_addr = 12'h080; req_id = 1'b0; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_val("stall_rsp_valid", rsp_valid, 1);
            check_val("stall_rdata", rsp_rdata, snap);
            check_val("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        check_val("stall_hs_req_ready", req_ready, 0);
        cmp_rsp("stall");
        @(posedge clk); #1;
        @(negedge clk);
        check_val("after_hs_req_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        begin
            exp_t e;
            e.rdata = ref_mem[8'h08]; e.we = 1'b0; e.err = 1'b0; e.id = 1'b0;
            sb.push_back(e);
        end
        wait_rsp("queued_rd", lat);

        // reset while waiting on the write response
        b_block = 1'b1;
        do_req(1, 12'h0c0, 128'h44, 16'h000f, 1, 0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_val("wresp_reached", got, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("midrst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        check_val("midrst_req_ready", req_ready, 1);
        if (sb.size() != 0) void'(sb.pop_back());
        b_block = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        check_val("midrst_no_rsp", got, 0);
        @(posedge clk); #1;

        txn("post_rst_rd", 0, 12'h047, '0, '0, 0, 0, lat);

        check_val("protocol_viol", viol, 0);
        check_val("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/axi_req_master.md
AXI_REQ_MASTER -- requirements
Module: axi_req_master

Interface
- Parameters:
REQ-001: C_AXI_ADDR_WIDTH, default 12, byte-address width of request and AXI address buses.
REQ-002: C_AXI_DATA_WIDTH, default 128, data width in bits; SHALL be a power of two and at least 8.
REQ-003: STRB_WIDTH, default C_AXI_DATA_WIDTH/8, byte-strobe width.
REQ-004: ID_WIDTH, default 1, width of request ID and AXI ID.
- Ports (name, direction, width, meaning):
REQ-005: clk  in  1  single clock; all logic is on the rising edge.
REQ-006: rst  in  1  reset; synchronous, active-high.
REQ-007: req_valid/req_ready  in/out  1/1  request handshake.
REQ-008: req_we  in  1  1=write, 0=read.
REQ-009: req_addr  in  C_AXI_ADDR_WIDTH  byte address.
REQ-010: req_wdata/req_wstrb  in  C_AXI_DATA_WIDTH/STRB_WIDTH  write payload and byte enables.
REQ-011: req_id  in  ID_WIDTH  tag returned with the response.
REQ-012: rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-013: rsp_rdata  out  C_AXI_DATA_WIDTH; rsp_we out 1; rsp_err out 1; rsp_id out ID_WIDTH.
REQ-014: m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*: full AXI4 master ports; widths and directions mirror the AXI4 slave RAM port list.

Function
REQ-015: At most one transaction outstanding; states IDLE, WRITE, WRESP, RADDR, RDATA, RSP.
REQ-016: req_ready=1 only in IDLE; on req_valid&&req_ready, latch all req_* fields; go to WRITE if req_we, else RADDR.
REQ-017: WRITE: m_axi_awvalid and m_axi_wvalid assert together on the first WRITE cycle; each deasserts on the cycle after its own handshake; both channels complete in either order or the same cycle.
REQ-018: When both AW and W have completed, go to WRESP with m_axi_bready=1; on bvalid, capture bresp and go to RSP.
REQ-019: RADDR: m_axi_arvalid=1 until arready; then RDATA with m_axi_rready=1; on rvalid, capture rdata and rresp and go to RSP.
REQ-020: RSP: rsp_valid=1 with stable outputs until rsp_ready; then IDLE. rsp_ready held 0 stalls indefinitely with no new request accepted.
REQ-021: rsp_err=1 if the captured resp!=2'b00, or on a read beat with rlast=0; otherwise 0. rsp_we and rsp_id are the latched values. rsp_rdata is 0 for writes.
REQ-022: AW/AR fields: addr = latched address with low log2(STRB_WIDTH) bits forced to 0; len=0; size=log2(STRB_WIDTH); burst=2'b01; lock=0; cache=4'b0000; prot=3'b000; id=latched req_id.
REQ-023: W fields: wdata/wstrb latched; wlast=1 whenever wvalid=1.
REQ-024: All AXI valid outputs are registered; a valid, once asserted, SHALL stay asserted with stable payload until its handshake.
REQ-025: bvalid/rvalid outside WRESP/RDATA are ignored, and bready/rready SHALL be 0 outside those states.
REQ-026: Minimum latency: a write with aw/wready tied high and a 1-cycle bvalid yields rsp_valid 3 cycles after req acceptance; a read yields rsp_valid 3 cycles after acceptance with a similar slave.

Reset
REQ-027: While rst=1: state=IDLE; req_ready=0; rsp_valid, awvalid, wvalid, arvalid, bready, rready=0; rsp_err=0. req_ready=1 from the first cycle after rst deasserts.
REQ-028: rst mid-transaction SHALL abandon the transaction silently; no response is issued.
REQ-029: Datapath registers need no reset.

Verification
REQ-030: Against the AXI4 slave RAM, write 0x0123..EF (all strobes) at 0x040, then read 0x040 -> rsp_rdata matches, rsp_err=0 for both.
REQ-031: Write with wstrb=0x0001 at 0x047 -> awaddr=0x040; a read-back shows only byte 0 changed.
REQ-032: Slave takes awready 3 cycles before wready, then the reverse order -> each valid drops independently; exactly one bready handshake; one response.
REQ-033: Slave returns bresp=2'b10, then rresp=2'b11 -> rsp_err=1 with the correct rsp_id each time.
REQ-034: Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp outputs stable; req_ready=0 until the cycle after the rsp handshake.
REQ-035: Assert rst for 1 cycle while in WRESP -> all valids/readies drop next cycle; IDLE; no rsp_valid produced.
